// File: rtl/wb_master.sv
// Wishbone classic burst master: one command moves 1..16 beats at
// incrementing addresses, with per-beat ack timeout.
//
// Ports:
//   clk_i, rst_i                      clock, sync active-high reset
//   adr_o dat_o dat_i we_o cyc_o stb_o ack_i   Wishbone bus
//   cmd_valid_i cmd_ready_o cmd_we_i cmd_adr_i cmd_len_i   command
//   wdat_valid_i wdat_i wdat_ready_o  write-data stream
//   rsp_valid_o rsp_dat_o done_o err_o  read beats / completion
module wb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  we_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic                  ack_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_len_i,
  input  logic                  wdat_valid_i,
  input  logic [DATA_WIDTH-1:0] wdat_i,
  output logic                  wdat_ready_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    BUS,
    GAP
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            beat_q, beat_d;
  logic [7:0]            cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_dat_d   = rsp_dat_q;
    len_d       = len_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d   = cmd_we_i;
          adr_d  = cmd_adr_i;
          len_d  = cmd_len_i;
          beat_d = 4'd0;
          cnt_d  = 8'd0;
          cyc_d  = 1'b1;
          if (cmd_we_i) begin
            state_d = WDATA;
            stb_d   = 1'b0;
          end else begin
            state_d = BUS;
            stb_d   = 1'b1;
          end
        end
      end
      WDATA: begin
        if (wdat_valid_i) begin
          dat_d   = wdat_i;
          state_d = BUS;
          stb_d   = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      BUS: begin
        // An ack on the expiring cycle wins over the timeout.
        if (ack_i) begin
          stb_d = 1'b0;
          if (!we_q) begin
            rsp_valid_d = 1'b1;
            rsp_dat_d   = dat_i;
          end
          if (beat_q == len_q) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            beat_d  = beat_q + 4'd1;
            adr_d   = adr_q + ADDR_WIDTH'(1);
            state_d = we_q ? WDATA : GAP;
          end
        end else if (cnt_q == TMAX) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        state_d = BUS;
        stb_d   = 1'b1;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      done_q      <= done_d;
      err_q       <= err_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ready drops combinationally while reset is held.
  assign cmd_ready_o  = (state_q == IDLE) && !rst_i;
  assign wdat_ready_o = (state_q == WDATA);
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign we_o         = we_q;
  assign cyc_o        = cyc_q;
  assign stb_o        = stb_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master: command table driven through a
// cycle-level slave model, plus reset and stray-ack sequences.
module tb_wb_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic        we_o, cyc_o, stb_o;
  logic        ack_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [7:0]  cmd_adr_i = '0;
  logic [3:0]  cmd_len_i = '0;
  logic        wdat_valid_i = 1'b0;
  logic [31:0] wdat_i = '0;
  logic        wdat_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        done_o, err_o;

  int tests = 0;
  int fails = 0;

  wb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wdat_valid_i(wdat_valid_i), .wdat_i(wdat_i),
    .wdat_ready_o(wdat_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       we;
    logic [7:0] adr;
    logic [3:0] len;
    int         ack_at;
    int         stall;
    int         exp_err;
    int         exp_rsp;
    int         exp_stb;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] rd(logic [7:0] a);
    return {a, ~a, 8'h5A, a};
  endfunction

  function automatic logic [31:0] wd(logic [7:0] a, int b);
    return {16'hC0DE, a, 8'(b)};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int beat, wbeat, run, maxrun, low, rsp, wcnt;
    bit fin;
    logic [7:0] ea, pa;
    beat = 0; wbeat = 0; run = 0; maxrun = 0;
    low = 0; rsp = 0; wcnt = 0; fin = 0;
    cmd_we_i = v.we;
    cmd_adr_i = v.adr;
    cmd_len_i = v.len;
    cmd_valid_i = 1'b1;
    chk($sformatf("v%0d cmd_ready", idx), 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid_i = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      ea = v.adr + 8'(beat);
      if (rsp_valid_o) begin
        rsp++;
        pa = v.adr + 8'(beat) - 8'd1;
        chk($sformatf("v%0d rsp_dat", idx), rsp_dat_o, rd(pa));
      end
      if (done_o) begin
        fin = 1;
        ack_i = 1'b0;
        wdat_valid_i = 1'b0;
        chk($sformatf("v%0d err", idx), 32'(err_o), 32'(v.exp_err));
        chk($sformatf("v%0d rsp_cnt", idx), 32'(rsp), 32'(v.exp_rsp));
        chk($sformatf("v%0d stb_run", idx), 32'(maxrun), 32'(v.exp_stb));
        chk($sformatf("v%0d done_cyc", idx), {30'd0, cyc_o, stb_o}, 32'd0);
        chk($sformatf("v%0d done_rdy", idx), 32'(cmd_ready_o), 32'd1);
        if (v.exp_err == 0)
          chk($sformatf("v%0d beats", idx), 32'(beat), 32'(v.len) + 1);
      end else begin
        chk($sformatf("v%0d cyc", idx), 32'(cyc_o), 32'd1);
        if (stb_o) begin
          if (run == 0) begin
            chk($sformatf("v%0d adr", idx), 32'(adr_o), 32'(ea));
            chk($sformatf("v%0d we", idx), 32'(we_o), 32'(v.we));
            if (v.we)
              chk($sformatf("v%0d dat_o", idx), dat_o, wd(v.adr, beat));
            else if (beat > 0)
              chk($sformatf("v%0d gap", idx), 32'(low), 32'd1);
          end
          run++;
          if (run > maxrun) maxrun = run;
          low = 0;
        end else begin
          run = 0;
          low++;
        end
        if (stb_o && v.ack_at != 0 && run == v.ack_at) begin
          ack_i = 1'b1;
          dat_i = rd(ea);
          beat++;
        end else begin
          ack_i = 1'b0;
          dat_i = 32'hDEAD_BEEF;
        end
        if (wdat_ready_o) begin
          wcnt++;
          if (wbeat != 1 || wcnt > v.stall) begin
            wdat_valid_i = 1'b1;
            wdat_i = wd(v.adr, wbeat);
            wbeat++;
            wcnt = 0;
          end else begin
            wdat_valid_i = 1'b0;
          end
        end else begin
          wdat_valid_i = 1'b0;
        end
      end
      tick();
    end
    ack_i = 1'b0;
    wdat_valid_i = 1'b0;
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL v%0d no_done: got none expected done_o", idx);
    end else begin
      chk($sformatf("v%0d done_pulse", idx), 32'(done_o), 32'd0);
    end
  endtask

  initial begin
    int n;
    bit got;
    vecs[0] = '{1'b0, 8'h00, 4'd0, 2, 0, 0, 1, 2};
    vecs[1] = '{1'b0, 8'hFE, 4'd3, 2, 0, 0, 4, 2};
    vecs[2] = '{1'b1, 8'h10, 4'd1, 1, 5, 0, 0, 1};
    vecs[3] = '{1'b0, 8'h20, 4'd0, 0, 0, 1, 0, 16};
    vecs[4] = '{1'b0, 8'h30, 4'd0, 16, 0, 0, 1, 16};
    vecs[5] = '{1'b1, 8'hFF, 4'd2, 3, 0, 0, 0, 3};
    vecs[6] = '{1'b1, 8'h80, 4'd1, 0, 0, 1, 0, 16};

    tick();
    tick();
    chk("rst_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_ctl", {25'd0, cyc_o, stb_o, we_o, rsp_valid_o,
                    done_o, err_o, wdat_ready_o}, 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rsp", rsp_dat_o, 32'd0);
    rst_i = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready_o), 32'd1);

    ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_ack", {29'd0, cyc_o, done_o, rsp_valid_o}, 32'd0);
    end
    ack_i = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    cmd_we_i = 1'b0;
    cmd_adr_i = 8'h40;
    cmd_len_i = 4'd3;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    got = 0;
    n = 0;
    while (!got && n < 50) begin
      if (rsp_valid_o) begin
        got = 1;
        ack_i = 1'b0;
      end else begin
        ack_i = stb_o;
        dat_i = rd(8'h40);
        tick();
        n++;
      end
    end
    chk("mid_beat1", 32'(got), 32'd1);
    chk("mid_beat1_dat", rsp_dat_o, rd(8'h40));
    rst_i = 1'b1;
    tick();
    chk("mid_rst_bus", {29'd0, cyc_o, stb_o, done_o}, 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(cmd_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_done", {30'd0, done_o, cyc_o}, 32'd0);
    end
    run_vec(7, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 8, Wishbone address width; DATA_WIDTH, 32, Wishbone data width; TIMEOUT, 16, stb-high cycles without ack before abort (range 2..255).
REQ-002 Ports (name, direction, width, meaning): clk_i, in, 1, sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-003 rst_i, in, 1, synchronous active-high reset.
REQ-004 Wishbone side: adr_o out ADDR_WIDTH; dat_o out DATA_WIDTH; dat_i in DATA_WIDTH; we_o out 1; cyc_o out 1; stb_o out 1; ack_i in 1.
REQ-005 Command side: cmd_valid_i in 1; cmd_ready_o out 1; cmd_we_i in 1 (1=write); cmd_adr_i in ADDR_WIDTH (start address); cmd_len_i in 4 (beats minus one, 1..16 beats).
REQ-006 Write data: wdat_valid_i in 1; wdat_i in DATA_WIDTH; wdat_ready_o out 1.
REQ-007 Response: rsp_valid_o out 1 (read-beat strobe); rsp_dat_o out DATA_WIDTH; done_o out 1 (end-of-command strobe); err_o out 1 (timeout flag, valid with done_o).

Function
REQ-008 States: IDLE, WDATA (write beat waiting for data), BUS (cyc and stb high, waiting ack), GAP (read inter-beat, stb low).
REQ-009 cmd_ready_o SHALL be 1 exactly when state is IDLE; command accepted on an edge with cmd_valid_i and cmd_ready_o both 1; command fields latched then.
REQ-010 Accepted read: next cycle state BUS, cyc_o=1, stb_o=1, we_o=0, adr_o=cmd_adr_i.
REQ-011 Accepted write: next cycle state WDATA, cyc_o=1, stb_o=0, we_o=1, wdat_ready_o=1; wdat_ready_o SHALL be 1 only in WDATA.
REQ-012 WDATA: on edge with wdat_valid_i=1, dat_o latches wdat_i, state BUS, stb_o=1 next cycle; otherwise remain, no timeout counting.
REQ-013 BUS: on edge with ack_i=1, stb_o drops next cycle; read beats SHALL present dat_i on rsp_dat_o with rsp_valid_o=1 for exactly that one cycle.
REQ-014 After a non-final ack: adr_o increments by 1 (wraps modulo 2^ADDR_WIDTH); reads go GAP for one cycle then BUS; writes go WDATA; cyc_o stays 1 throughout.
REQ-015 After the final ack (beat count = cmd_len_i+1): cyc_o=0, stb_o=0, done_o=1, err_o=0 for one cycle, state IDLE (cmd_ready_o=1 that same cycle).
REQ-016 Timeout counter clears on every BUS entry, increments each BUS cycle with ack_i=0; at TIMEOUT consecutive such cycles, next cycle cyc_o=0, stb_o=0, done_o=1, err_o=1, state IDLE; remaining beats discarded, no rsp_valid_o.
REQ-017 ack_i on the edge the counter would expire SHALL be honoured as a normal ack (no error).
REQ-018 ack_i outside BUS SHALL be ignored.
REQ-019 rsp_valid_o and done_o SHALL never assert for write commands except done_o/err_o at end.
REQ-020 adr_o, dat_o, we_o SHALL stay stable while stb_o=1.

Reset
REQ-021 On an edge with rst_i=1: state IDLE; cyc_o, stb_o, we_o, rsp_valid_o, done_o, err_o, wdat_ready_o = 0; adr_o, dat_o, rsp_dat_o = 0; counters 0; cmd_ready_o = 0 while rst_i=1 and 1 from the first cycle after.
REQ-022 Reset mid-command SHALL drop cyc_o/stb_o at that edge, discard the command and emit no done_o.

Verification
REQ-023 Single read: cmd adr=0x00, len=0, slave acks 1 cycle after stb -> one rsp_valid_o with slave data, done_o=1 err_o=0, cyc_o low same cycle.
REQ-024 Block read: adr=0xFE, len=3 -> adr_o 0xFE,0xFF,0x00,0x01; four rsp_valid_o pulses; stb_o low one cycle between beats; cyc_o continuous.
REQ-025 Block write with data stall: len=1, wdat_valid_i withheld 5 cycles before beat 2 -> stb_o low, cyc_o high during stall; dat_o matches each wdat_i; done_o err_o=0.
REQ-026 Timeout: TIMEOUT=16, slave never acks -> stb_o high exactly 16 cycles, then cyc_o=0, done_o=1, err_o=1; ack on cycle 16 instead -> err_o=0.
REQ-027 Reset mid-block read after beat 1 -> cyc_o/stb_o 0 next cycle, no done_o, cmd_ready_o 1 after rst_i releases; new command then completes normally.
